// File: rtl/aes_arb_pkg.sv
// Shared types for the AES request arbiter: FSM state encoding and block width.
package aes_arb_pkg;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    ISSUE_S = 2'd1,
    WAIT_S  = 2'd2,
    RESP_S  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: first valid requester at or after the pointer.
// The pointer moves to one past the winner whenever the caller takes the grant.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_valid
);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] cand_idx_s;
  logic            found_s;
  logic            hit_s;
  int              cand_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    found_s    = 1'b0;
    idx_s      = {ID_W{1'b0}};
    cand_s     = 0;
    cand_idx_s = {ID_W{1'b0}};
    hit_s      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s     = (int'(ptr_r) + i) % NUM_REQ;
      cand_idx_s = ID_W'(cand_s);
      hit_s      = req[cand_idx_s] && !found_s;
      idx_s      = hit_s ? cand_idx_s : idx_s;
      found_s    = found_s | hit_s;
    end
  end

  // Pointer register, advanced past the winner on a taken grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (adv) begin
      ptr_r <= (idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : idx_s + ID_W'(1);
    end
  end

  assign gnt       = found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_s) : {NUM_REQ{1'b0}};
  assign gnt_idx   = idx_s;
  assign gnt_valid = found_s;

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 encrypt core between NUM_REQ requesters: round-robin grant,
// start/done sequencing, watchdog-terminated error response, per-requester response.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 1023,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [AES_BLK_W-1:0]           rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           busy_o,
  output logic [ID_W-1:0]                grant_id_o,
  output logic                           aes_start_o,
  output logic [AES_BLK_W-1:0]           aes_key_o,
  output logic [AES_BLK_W-1:0]           aes_pt_o,
  input  logic [AES_BLK_W-1:0]           aes_ct_i,
  input  logic                           aes_ready_i,
  input  logic                           aes_done_i
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_r;
  arb_state_t           state_next_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [ID_W-1:0]      gnt_idx_s;
  logic                 gnt_valid_s;
  logic                 take_s;
  logic                 timeout_s;
  logic [WD_W-1:0]      wdog_r;
  logic [AES_BLK_W-1:0] sel_key_s;
  logic [AES_BLK_W-1:0] sel_pt_s;
  logic                 aes_start_r;
  logic [AES_BLK_W-1:0] aes_key_r;
  logic [AES_BLK_W-1:0] aes_pt_r;
  logic [AES_BLK_W-1:0] rsp_data_r;
  logic                 rsp_err_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [ID_W-1:0]      grant_id_r;

  // A grant is only taken in IDLE and never while reset is being sampled.
  assign take_s    = (state_r == IDLE_S) && gnt_valid_s && rst_n;
  assign timeout_s = (wdog_r == WD_LAST);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid_i),
    .adv       (take_s),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Key/plaintext mux for the winning requester.
  always_comb begin
    sel_key_s = {AES_BLK_W{1'b0}};
    sel_pt_s  = {AES_BLK_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_s == ID_W'(i)) begin
        sel_key_s = req_key_i[i*AES_BLK_W +: AES_BLK_W];
        sel_pt_s  = req_data_i[i*AES_BLK_W +: AES_BLK_W];
      end else begin
        sel_key_s = sel_key_s;
        sel_pt_s  = sel_pt_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE_S;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; done has priority over the watchdog.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE_S:  if (take_s) state_next_s = ISSUE_S; else state_next_s = IDLE_S;
      ISSUE_S: if (aes_ready_i) state_next_s = WAIT_S; else state_next_s = ISSUE_S;
      WAIT_S:  if (aes_done_i || timeout_s) state_next_s = RESP_S; else state_next_s = WAIT_S;
      RESP_S:  if (rsp_ready_i[grant_id_r]) state_next_s = IDLE_S; else state_next_s = RESP_S;
      default: state_next_s = IDLE_S;
    endcase
  end

  // Datapath: capture, start pulse, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aes_start_r <= 1'b0;
      aes_key_r   <= {AES_BLK_W{1'b0}};
      aes_pt_r    <= {AES_BLK_W{1'b0}};
      rsp_data_r  <= {AES_BLK_W{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_valid_r <= {NUM_REQ{1'b0}};
      grant_id_r  <= {ID_W{1'b0}};
      wdog_r      <= {WD_W{1'b0}};
    end else begin
      aes_start_r <= 1'b0;
      case (state_r)
        IDLE_S: begin
          if (take_s) begin
            aes_key_r  <= sel_key_s;
            aes_pt_r   <= sel_pt_s;
            grant_id_r <= gnt_idx_s;
          end
        end
        ISSUE_S: begin
          if (aes_ready_i) begin
            aes_start_r <= 1'b1;
            wdog_r      <= {WD_W{1'b0}};
          end
        end
        WAIT_S: begin
          wdog_r <= wdog_r + WD_W'(1);
          if (aes_done_i) begin
            rsp_data_r  <= aes_ct_i;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
          end else if (timeout_s) begin
            rsp_data_r  <= {AES_BLK_W{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
          end
        end
        RESP_S: begin
          if (rsp_ready_i[grant_id_r]) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
          end
        end
        default: begin
          rsp_valid_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  assign req_ready_o = take_s ? gnt_s : {NUM_REQ{1'b0}};
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_err_o   = rsp_err_r;
  assign busy_o      = (state_r != IDLE_S);
  assign grant_id_o  = grant_id_r;
  assign aes_start_o = aes_start_r;
  assign aes_key_o   = aes_key_r;
  assign aes_pt_o    = aes_pt_r;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter with a behavioural stub encrypt core
// and a requester-level model (rotating pick, expected ciphertext per request).
module tb_aes_req_arbiter;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk, rst_n;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [511:0] req_key, req_data;
  logic [127:0] rsp_data, aes_key, aes_pt, aes_ct;
  logic rsp_err, busy, aes_start, aes_ready, aes_done;
  logic [1:0] grant_id;
  logic [127:0] key_a [4];
  logic [127:0] pt_a [4];

  int checks = 0, failures = 0, model_ptr = 0;

  // Stub core controls and state
  bit stub_hang, stub_release, late_done;
  int stub_lat;
  logic [127:0] late_ct;
  logic stub_busy_r, stub_done_r;
  logic [127:0] stub_ct_r, stub_res_r;
  int stub_cnt_r;

  aes_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .busy_o(busy), .grant_id_o(grant_id),
    .aes_start_o(aes_start), .aes_key_o(aes_key), .aes_pt_o(aes_pt),
    .aes_ct_i(aes_ct), .aes_ready_i(aes_ready), .aes_done_i(aes_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_key[i*128 +: 128]  = key_a[i];
      req_data[i*128 +: 128] = pt_a[i];
    end
  end

  function automatic logic [127:0] enc_model(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {k[63:0], k[127:64]} ^ p ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // First valid requester at or after pointer p, or -1.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub core: accepts start when idle, answers after stub_lat cycles unless hung.
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_busy_r <= 1'b0; stub_done_r <= 1'b0; stub_cnt_r <= 0;
      stub_ct_r <= 128'd0; stub_res_r <= 128'd0;
    end else begin
      stub_done_r <= 1'b0;
      if (stub_release) begin
        stub_busy_r <= 1'b0;
      end else if (!stub_busy_r && aes_start) begin
        stub_busy_r <= 1'b1;
        stub_cnt_r  <= stub_lat;
        stub_res_r  <= enc_model(aes_key, aes_pt);
      end else if (stub_busy_r && !stub_hang) begin
        if (stub_cnt_r == 0) begin
          stub_busy_r <= 1'b0; stub_done_r <= 1'b1; stub_ct_r <= stub_res_r;
        end else begin
          stub_cnt_r <= stub_cnt_r - 1;
        end
      end
    end
  end

  assign aes_ready = !stub_busy_r;
  assign aes_done  = stub_done_r | late_done;
  assign aes_ct    = late_done ? late_ct : stub_ct_r;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_rsp(output bit ok);
    for (int c = 0; c < 100 && rsp_valid == 4'b0000; c++) tick();
    ok = (rsp_valid != 4'b0000);
  endtask

  task automatic wait_start(output bit ok);
    for (int c = 0; c < 30 && !aes_start; c++) tick();
    ok = aes_start;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, busy, grant_id, aes_start} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl: valid=%b err=%b busy=%b gid=%0d start=%b want all 0", rsp_valid, rsp_err, busy, grant_id, aes_start);
    end
    checks++;
    if ({rsp_data, aes_key, aes_pt} !== 384'd0) begin
      failures++; $display("FAIL reset_data: data=%h key=%h pt=%h want 0", rsp_data, aes_key, aes_pt);
    end
    req_valid = 4'b0000; rst_n = 1'b1; model_ptr = 0;
    tick();
  endtask

  task automatic test_fips();
    int starts; bit ok;
    key_a[2] = FIPS_KEY; pt_a[2] = FIPS_PT; req_valid = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL fips_ready: got %b want 0100", req_ready); end
    model_ptr = 3;
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL fips_ready_once: got %b want 0000", req_ready); end
    req_valid = 4'b0000;
    starts = 0;
    for (int c = 0; c < 100 && rsp_valid == 4'b0000; c++) begin
      if (aes_start) starts++;
      tick();
    end
    checks++;
    if (starts != 1) begin failures++; $display("FAIL fips_start_pulses: got %0d want 1", starts); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, grant_id} !== {4'b0100, 1'b0, FIPS_CT, 2'd2}) begin
      failures++; $display("FAIL fips_rsp: valid=%b err=%b data=%h gid=%0d want 0100 0 %h 2", rsp_valid, rsp_err, rsp_data, grant_id, FIPS_CT);
    end
    rsp_ready = 4'b0100; tick(); rsp_ready = 4'b0000;
    checks++;
    if ({rsp_valid, busy} !== 5'b00000) begin failures++; $display("FAIL fips_release: valid=%b busy=%b want 0000 0", rsp_valid, busy); end
    ok = 1'b1;
  endtask

  task automatic test_round_robin();
    int g; bit ok; logic [3:0] oh; logic [127:0] exp_ct;
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_ptr = 0;
    for (int i = 0; i < 4; i++) begin key_a[i] = rnd128(); pt_a[i] = rnd128(); end
    req_valid = 4'b1111; #1;
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 20 && req_ready == 4'b0000; c++) tick();
      g = pick(req_valid, model_ptr);
      oh = 4'b0001 << g;
      checks++;
      if (req_ready !== oh || g != t % 4) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, 4'b0001 << (t % 4));
      end
      model_ptr = (g + 1) % 4;
      exp_ct = enc_model(key_a[g], pt_a[g]);
      stub_lat = $urandom_range(0, 12);
      tick();
      key_a[g] = rnd128(); pt_a[g] = rnd128();
      wait_rsp(ok);
      checks++;
      if (!ok || {rsp_valid, rsp_err, rsp_data} !== {oh, 1'b0, exp_ct}) begin
        failures++; $display("FAIL rr_rsp[%0d]: valid=%b err=%b data=%h want %b 0 %h", t, rsp_valid, rsp_err, rsp_data, oh, exp_ct);
      end
      rsp_ready = ~oh;
      for (int d = 0; d < int'($urandom_range(1, 3)); d++) tick();
      checks++;
      if (rsp_valid !== oh) begin failures++; $display("FAIL rr_foreign_ready[%0d]: valid=%b want %b", t, rsp_valid, oh); end
      rsp_ready = 4'b1111; tick(); rsp_ready = 4'b0000; #1;
    end
    req_valid = 4'b0000; tick();
  endtask

  task automatic test_backpressure();
    int g, bad; bit ok; logic [127:0] exp_ct;
    key_a[1] = rnd128(); pt_a[1] = rnd128(); stub_lat = 4;
    req_valid = 4'b0010; #1;
    g = pick(req_valid, model_ptr);
    checks++;
    if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'b0001 << g); end
    model_ptr = (g + 1) % 4;
    exp_ct = enc_model(key_a[1], pt_a[1]);
    tick(); req_valid = 4'b0000;
    wait_rsp(ok);
    rsp_ready = 4'b1101; key_a[0] = rnd128(); pt_a[0] = rnd128(); req_valid = 4'b0001;
    bad = ok ? 0 : 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid !== 4'b0010 || rsp_data !== exp_ct || rsp_err !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d bad cycles want 0 (valid=%b data=%h)", bad, rsp_valid, rsp_data); end
    rsp_ready = 4'b0010; tick(); rsp_ready = 4'b0000; #1;
    g = pick(req_valid, model_ptr);
    checks++;
    if ({rsp_valid, busy, req_ready} !== {4'b0000, 1'b0, 4'b0001 << g}) begin
      failures++; $display("FAIL bp_release: valid=%b busy=%b ready=%b want 0000 0 %b", rsp_valid, busy, req_ready, 4'b0001 << g);
    end
    model_ptr = (g + 1) % 4;
    exp_ct = enc_model(key_a[0], pt_a[0]);
    tick(); req_valid = 4'b0000;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_valid, rsp_data} !== {4'b0001, exp_ct}) begin
      failures++; $display("FAIL bp_next: valid=%b data=%h want 0001 %h", rsp_valid, rsp_data, exp_ct);
    end
    rsp_ready = 4'b0001; tick(); rsp_ready = 4'b0000;
  endtask

  task automatic test_timeout();
    int g, c, bad; bit ok; logic [127:0] exp_ct;
    stub_hang = 1'b1; key_a[3] = rnd128(); pt_a[3] = rnd128();
    req_valid = 4'b1000; #1;
    g = pick(req_valid, model_ptr);
    checks++;
    if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL to_grant: got %b want %b", req_ready, 4'b0001 << g); end
    model_ptr = (g + 1) % 4;
    tick(); req_valid = 4'b0000;
    wait_start(ok);
    c = 0;
    while (ok && rsp_valid == 4'b0000 && c < 400) begin c++; tick(); end
    checks++;
    if (c != 256) begin failures++; $display("FAIL to_wait_cycles: got %0d want 256", c); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b1000, 1'b1, 128'd0}) begin
      failures++; $display("FAIL to_rsp: valid=%b err=%b data=%h want 1000 1 0", rsp_valid, rsp_err, rsp_data);
    end
    late_ct = rnd128(); late_done = 1'b1; tick(); late_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b1000, 1'b1, 128'd0}) begin
      failures++; $display("FAIL to_late_done: valid=%b err=%b data=%h want 1000 1 0", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 4'b1000; tick(); rsp_ready = 4'b0000;
    late_done = 1'b1; tick(); late_done = 1'b0;
    key_a[0] = rnd128(); pt_a[0] = rnd128(); req_valid = 4'b0001; #1;
    g = pick(req_valid, model_ptr);
    checks++;
    if ({busy, req_ready} !== {1'b0, 4'b0001 << g}) begin
      failures++; $display("FAIL to_idle_after: busy=%b ready=%b want 0 %b", busy, req_ready, 4'b0001 << g);
    end
    model_ptr = (g + 1) % 4;
    exp_ct = enc_model(key_a[0], pt_a[0]);
    tick(); req_valid = 4'b0000;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (aes_start || !busy || rsp_valid != 4'b0000) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL to_issue_waits_ready: %0d bad cycles want 0", bad); end
    stub_hang = 1'b0; stub_lat = 2; stub_release = 1'b1; tick(); stub_release = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_valid, rsp_err, rsp_data} !== {4'b0001, 1'b0, exp_ct}) begin
      failures++; $display("FAIL to_recover: valid=%b err=%b data=%h want 0001 0 %h", rsp_valid, rsp_err, rsp_data, exp_ct);
    end
    rsp_ready = 4'b0001; tick(); rsp_ready = 4'b0000;
  endtask

  task automatic test_done_timeout();
    int g, c; bit ok;
    stub_hang = 1'b1; key_a[2] = rnd128(); pt_a[2] = rnd128();
    req_valid = 4'b0100; #1;
    g = pick(req_valid, model_ptr);
    model_ptr = (g + 1) % 4;
    tick(); req_valid = 4'b0000;
    wait_start(ok);
    c = 1;
    while (c < 256) begin tick(); c++; end
    checks++;
    if (!ok || rsp_valid !== 4'b0000) begin failures++; $display("FAIL dt_early: valid=%b start_seen=%b want 0000 1", rsp_valid, ok); end
    late_ct = rnd128(); late_done = 1'b1; tick(); late_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b0100, 1'b0, late_ct}) begin
      failures++; $display("FAIL dt_done_wins: valid=%b err=%b data=%h want 0100 0 %h", rsp_valid, rsp_err, rsp_data, late_ct);
    end
    rsp_ready = 4'b0100; tick(); rsp_ready = 4'b0000;
    stub_hang = 1'b0; stub_release = 1'b1; tick(); stub_release = 1'b0;
  endtask

  task automatic test_mid_reset();
    int g, bad; bit ok; logic [127:0] exp_ct;
    stub_lat = 30; key_a[0] = rnd128(); pt_a[0] = rnd128();
    req_valid = 4'b0001; #1;
    g = pick(req_valid, model_ptr);
    tick(); req_valid = 4'b0000;
    wait_start(ok); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_ptr = 0;
    checks++;
    if ({rsp_valid, rsp_err, busy, grant_id, aes_start, rsp_data, aes_key, aes_pt} !== 393'd0 || !ok || g != 0) begin
      failures++; $display("FAIL mr_outputs: valid=%b busy=%b gid=%0d key=%h want all 0", rsp_valid, busy, grant_id, aes_key);
    end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid != 4'b0000 || busy) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mr_no_response: %0d bad cycles want 0", bad); end
    stub_lat = 3; key_a[0] = rnd128(); pt_a[0] = rnd128(); key_a[3] = rnd128(); pt_a[3] = rnd128();
    req_valid = 4'b1001; #1;
    g = pick(req_valid, model_ptr);
    checks++;
    if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL mr_pointer: got %b want %b", req_ready, 4'b0001 << g); end
    model_ptr = (g + 1) % 4;
    exp_ct = enc_model(key_a[g], pt_a[g]);
    tick(); req_valid = 4'b0000;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_valid, rsp_err, rsp_data} !== {4'b0001 << g, 1'b0, exp_ct}) begin
      failures++; $display("FAIL mr_next_rsp: valid=%b err=%b data=%h want %b 0 %h", rsp_valid, rsp_err, rsp_data, 4'b0001 << g, exp_ct);
    end
    rsp_ready = 4'b1111; tick(); rsp_ready = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 4'b0000;
    stub_hang = 1'b0; stub_release = 1'b0; late_done = 1'b0; late_ct = 128'd0; stub_lat = 3;
    for (int i = 0; i < 4; i++) begin key_a[i] = 128'd0; pt_a[i] = 128'd0; end
    test_reset();
    test_fips();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_done_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within 500000 time units");
    $fatal(1, "bench time limit");
  end

endmodule
